result_bcd_convert: RTL and testbench

Downstream stage of the 20-bit two's-complement adder. Takes the adder's calculate_out word and converts it to sign plus 6-digit packed BCD magnitude for the display driver. Uses an iterative shift-add-3 (double-dabble) datapath, one bit per clock, with a start/done handshake. Holds the last result stable for the display until the next conversion completes.

---
 rtl/result_bcd_convert.sv | 113 +++++++++++
 tb/tb_result_bcd_convert.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_convert.sv
// Sign + packed-BCD converter for the adder result, iterative double-dabble (one bit per clock).
// Latency WIDTH+1 clocks from accepted start to done pulse; start is ignored while busy, no queuing.
module result_bcd_convert #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             done_q, done_d;
  logic [BW-1:0]    acc_adj;

  // Add-3 correction on every digit that would exceed 9 after the next doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = value[WIDTH-1];
          // Unsigned negate: the most negative input maps to its true magnitude.
          mag_d   = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d = {acc_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        neg_d   = sign_q;
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign neg  = neg_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_result_bcd_convert.sv
// Directed and reference-model bench for result_bcd_convert.
module tb_result_bcd_convert;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] value;
  logic        busy;
  logic        done;
  logic        neg;
  logic [23:0] bcd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  result_bcd_convert #(.WIDTH(20), .DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one conversion and reports what was observed; callers compare.
  task automatic run_conv(input logic [19:0] v, output int lat, output int busy_n,
                          output logic n_o, output logic [23:0] b_o,
                          output logic busy_at_done, output logic done_after);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = 20'($urandom);
    lat    = -1;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
      tick();
    end
    n_o          = neg;
    b_o          = bcd;
    busy_at_done = busy;
    tick();
    done_after = done;
  endtask

  function automatic logic [23:0] ref_bcd(input logic [19:0] v);
    logic signed [19:0] s;
    int m;
    logic [23:0] r;
    s = v;
    m = (s < 0) ? -int'(s) : int'(s);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    #23;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (neg !== 1'b0) $display("FAIL reset_neg got %b want 0", neg); else pass_cnt++;
    chk_cnt++; if (bcd !== 24'h0) $display("FAIL reset_bcd got %h want 000000", bcd); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bn;
    logic n, bd, da;
    logic [23:0] b;
    run_conv(20'h003FE, lat, bn, n, b, bd, da);
    chk_cnt++; if (lat !== 21) $display("FAIL basic_latency got %0d want 21", lat); else pass_cnt++;
    chk_cnt++; if (bn !== 21) $display("FAIL basic_busy_cycles got %0d want 21", bn); else pass_cnt++;
    chk_cnt++; if (bd !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bd); else pass_cnt++;
    chk_cnt++; if (n !== 1'b0) $display("FAIL basic_neg got %b want 0", n); else pass_cnt++;
    chk_cnt++; if (b !== 24'h001022) $display("FAIL basic_bcd got %h want 001022", b); else pass_cnt++;
    chk_cnt++; if (da !== 1'b0) $display("FAIL basic_done_width got %b want 0", da); else pass_cnt++;
    chk_cnt++; if (bcd !== 24'h001022) $display("FAIL basic_hold got %h want 001022", bcd); else pass_cnt++;
  endtask

  task automatic test_negative();
    logic [19:0] vin [2] = '{20'hFFC00, 20'hFFFFE};
    logic [23:0] vex [2] = '{24'h001024, 24'h000002};
    int lat, bn;
    logic n, bd, da;
    logic [23:0] b;
    for (int i = 0; i < 2; i++) begin
      run_conv(vin[i], lat, bn, n, b, bd, da);
      chk_cnt++; if (lat !== 21) $display("FAIL neg_latency[%0d] got %0d want 21", i, lat); else pass_cnt++;
      chk_cnt++; if (n !== 1'b1) $display("FAIL neg_sign[%0d] got %b want 1", i, n); else pass_cnt++;
      chk_cnt++; if (b !== vex[i]) $display("FAIL neg_bcd[%0d] got %h want %h", i, b, vex[i]); else pass_cnt++;
    end
  endtask

  task automatic test_extremes();
    logic [19:0] vin [3] = '{20'h7FFFF, 20'h80000, 20'h00000};
    logic [23:0] vex [3] = '{24'h524287, 24'h524288, 24'h000000};
    logic        nex [3] = '{1'b0, 1'b1, 1'b0};
    int lat, bn;
    logic n, bd, da;
    logic [23:0] b;
    for (int i = 0; i < 3; i++) begin
      run_conv(vin[i], lat, bn, n, b, bd, da);
      chk_cnt++; if (lat !== 21) $display("FAIL ext_latency[%0d] got %0d want 21", i, lat); else pass_cnt++;
      chk_cnt++; if (n !== nex[i]) $display("FAIL ext_sign[%0d] got %b want %b", i, n, nex[i]); else pass_cnt++;
      chk_cnt++; if (b !== vex[i]) $display("FAIL ext_bcd[%0d] got %h want %h", i, b, vex[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int t1 = -1, t2 = -1;
    logic [23:0] b1 = '0, b2 = '0, bmid = '0;
    start = 1'b1;
    value = 20'h001FF;
    tick();
    // n counts edges after the accepting edge
    for (int n = 1; n <= 70; n++) begin
      if (n == 5) value = 20'h000FF;
      tick();
      if (n == 22) start = 1'b0;
      if (n == 30) bmid = bcd;
      if (done) begin
        pulses++;
        if (pulses == 1) begin t1 = n; b1 = bcd; end
        if (pulses == 2) begin t2 = n; b2 = bcd; end
      end
    end
    chk_cnt++; if (t1 !== 21) $display("FAIL b2b_first_time got %0d want 21", t1); else pass_cnt++;
    chk_cnt++; if (b1 !== 24'h000511) $display("FAIL b2b_first_bcd got %h want 000511", b1); else pass_cnt++;
    chk_cnt++; if (bmid !== 24'h000511) $display("FAIL b2b_hold got %h want 000511", bmid); else pass_cnt++;
    chk_cnt++; if (t2 !== 43) $display("FAIL b2b_second_time got %0d want 43", t2); else pass_cnt++;
    chk_cnt++; if (b2 !== 24'h000255) $display("FAIL b2b_second_bcd got %h want 000255", b2); else pass_cnt++;
    chk_cnt++; if (pulses !== 2) $display("FAIL b2b_pulse_count got %0d want 2", pulses); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int lat, bn;
    logic n, bd, da;
    logic [23:0] b;
    start = 1'b1;
    value = 20'h7FFFF;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (neg !== 1'b0) $display("FAIL midrst_neg got %b want 0", neg); else pass_cnt++;
    chk_cnt++; if (bcd !== 24'h0) $display("FAIL midrst_bcd got %h want 000000", bcd); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) pulses++;
    end
    chk_cnt++; if (pulses !== 0) $display("FAIL midrst_no_done got %0d want 0", pulses); else pass_cnt++;
    run_conv(20'h12345, lat, bn, n, b, bd, da);
    chk_cnt++; if (lat !== 21) $display("FAIL midrst_latency got %0d want 21", lat); else pass_cnt++;
    chk_cnt++; if (n !== 1'b0) $display("FAIL midrst_neg_after got %b want 0", n); else pass_cnt++;
    chk_cnt++; if (b !== 24'h074565) $display("FAIL midrst_bcd_after got %h want 074565", b); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bn;
    logic n, bd, da;
    logic [23:0] b;
    logic [19:0] v;
    int a, c;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        v = 20'($urandom);
      end else begin
        a = int'($urandom_range(1022)) - 511;
        c = int'($urandom_range(1022)) - 511;
        v = 20'(a + c);
      end
      run_conv(v, lat, bn, n, b, bd, da);
      chk_cnt++; if (n !== v[19]) $display("FAIL rand_neg v=%h got %b want %b", v, n, v[19]); else pass_cnt++;
      chk_cnt++; if (b !== ref_bcd(v)) $display("FAIL rand_bcd v=%h got %h want %h", v, b, ref_bcd(v)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
